sar_conv_ctrl: RTL



---
 rtl/sar_conv_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: successive-approximation controller driving CDAC code, comparator strobe and result handoff
module sar_conv_ctrl #(
    parameter int NBITS    = 8,
    parameter int CMP_WAIT = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             comp_valid,
    input  logic             comp_out,
    output logic             comp_trig,
    output logic [NBITS-1:0] dac_code,
    output logic             eoc,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             timeout_err
);
    localparam int IW = $clog2(NBITS);
    localparam int SW = $clog2(CMP_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_CMP, DONE} state_t;

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [SW-1:0]    scnt, scnt_d;
    logic [TW-1:0]    wcnt, wcnt_d;
    logic [NBITS-1:0] code_d, dout_d;
    logic             dv_d, eoc_d, terr_d, tmo;

    assign comp_trig = state == TRIG;
    assign busy      = state != IDLE;
    assign tmo       = wcnt == TW'(TIMEOUT - 1) && !comp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= IW'(NBITS - 1);
            scnt        <= '0;
            wcnt        <= '0;
            dac_code    <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            eoc         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            scnt        <= scnt_d;
            wcnt        <= wcnt_d;
            dac_code    <= code_d;
            dout        <= dout_d;
            dout_valid  <= dv_d;
            eoc         <= eoc_d;
            timeout_err <= terr_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        scnt_d  = scnt;
        wcnt_d  = wcnt;
        code_d  = dac_code;
        dout_d  = dout;
        dv_d    = 1'b0;
        eoc_d   = eoc;
        terr_d  = timeout_err;
        // losing start mid-search abandons the conversion, even over a same-cycle decision
        if (busy && state != DONE && !start) begin
            state_d = IDLE;
            code_d  = '0;
        end else begin
            case (state)
                IDLE: if (start && !eoc) begin
                    state_d = SETTLE;
                    code_d  = {1'b1, {(NBITS-1){1'b0}}};
                    idx_d   = IW'(NBITS - 1);
                    terr_d  = 1'b0;
                    scnt_d  = SW'(CMP_WAIT - 1);
                end
                SETTLE: begin
                    state_d = scnt == '0 ? TRIG : SETTLE;
                    scnt_d  = scnt == '0 ? scnt : scnt - 1'b1;
                end
                TRIG: begin
                    wcnt_d  = '0;
                    state_d = WAIT_CMP;
                end
                WAIT_CMP: if (comp_valid || tmo) begin
                    code_d[idx] = comp_valid & comp_out;
                    terr_d      = timeout_err | tmo;
                    if (idx != '0) begin
                        code_d[idx - 1'b1] = 1'b1;
                        idx_d   = idx - 1'b1;
                        scnt_d  = SW'(CMP_WAIT - 1);
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                        dout_d  = code_d;
                        dv_d    = 1'b1;
                        eoc_d   = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
                DONE: if (!start) begin
                    state_d = IDLE;
                    eoc_d   = 1'b0;
                    code_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule
